// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding, read-during-write modes and lane-count helper for the buffer RAM.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_dp_be_clr_if.sv
// ram_dp_be_clr_if: write/read/clear bus of the byte-enable dual-port RAM.
interface ram_dp_be_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  clr;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  re;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output clr, we, be, wr_addr, data_in, re, rd_addr,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  clr, we, be, wr_addr, data_in, re, rd_addr,
        output data_out, rd_valid, busy
    );

endinterface

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear FSM stepping one address per cycle; drives the clear-write strobe and busy.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) state_d = ST_IDLE;
        end else if (clr_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end
    end

    assign busy_o     = state_q == ST_CLEAR;
    assign clr_we_o   = busy_o;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_dp_be_clr.sv
// ram_dp_be_clr: simple dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write result and a sequenced clear.
module ram_dp_be_clr
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_OLD
) (
    input logic            clk,
    input logic            rst,
    ram_dp_be_clr_if.slave bus
);

    localparam int NB    = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_be_clr: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_dp_be_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy, clr_we, wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] rd_word, s1_data_q, out_data;
    logic                  s1_v_q, out_v;

    ram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (bus.clr),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign wr_en = bus.we & ~busy;
    assign rd_en = bus.re & ~busy;

    // Clear sequence owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_addr] <= '0;
        else if (wr_en)
            for (int k = 0; k < NB; k++)
                if (bus.be[k]) mem[bus.wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in[k*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_comb begin
        rd_word = mem[bus.rd_addr];
        if (RDW_MODE == RDW_NEW && wr_en && bus.wr_addr == bus.rd_addr)
            for (int k = 0; k < NB; k++)
                if (bus.be[k]) rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in[k*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_v_q    <= 1'b0;
        end else begin
            s1_v_q <= rd_en;
            if (rd_en) s1_data_q <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_v_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_q <= '0;
                s2_v_q    <= 1'b0;
            end else begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) s2_data_q <= s1_data_q;
            end
        end
        assign out_data = s2_data_q;
        assign out_v    = s2_v_q;
    end else begin : g_lat1
        assign out_data = s1_data_q;
        assign out_v    = s1_v_q;
    end

    assign bus.data_out = out_data;
    assign bus.rd_valid = out_v;
    assign bus.busy     = busy;

endmodule
